// File: rtl/vga_fb_controller.sv
// VGA timing generator with a scaled on-chip framebuffer, a cursor-based CPU pixel
// port and a hardware clear engine. Video pipeline: counters -> RAM read -> output regs.
//
// state | meaning
// IDLE  | CPU owns the framebuffer write port
// CLEAR | clear engine writes one word per clock, addr 0..FB_W*FB_H-1
module vga_fb_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int HS_POL      = 0,
    parameter int VS_POL      = 0,
    parameter int CLK_DIV     = 2,
    parameter int SCALE_SHIFT = 2,
    parameter int CH_BITS     = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CE,
    input  logic               RW,
    input  logic [1:0]         ADDR,
    input  logic [7:0]         DATA,
    output logic [7:0]         DATA_OUT,
    output logic [CH_BITS-1:0] R,
    output logic [CH_BITS-1:0] G,
    output logic [CH_BITS-1:0] B,
    output logic               Hs,
    output logic               Vs
);
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW         = $clog2(H_TOTAL);
    localparam int VW         = $clog2(V_TOTAL);
    localparam int DW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int COLOR_BITS = 3 * CH_BITS;
    localparam int FB_W       = H_ACTIVE >> SCALE_SHIFT;
    localparam int FB_H       = V_ACTIVE >> SCALE_SHIFT;
    localparam int FB_SIZE    = FB_W * FB_H;
    localparam int AW         = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;
    localparam int HS_START   = H_ACTIVE + H_FP;
    localparam int HS_END     = HS_START + H_SYNC;
    localparam int VS_START   = V_ACTIVE + V_FP;
    localparam int VS_END     = VS_START + V_SYNC;
    localparam logic HS_ACT   = (HS_POL != 0);
    localparam logic VS_ACT   = (VS_POL != 0);

    typedef enum logic {IDLE, CLEAR} state_t;

    logic [DW-1:0]         div;
    logic                  pix_en;
    logic [HW-1:0]         sx;
    logic [VW-1:0]         sy;
    logic                  frame_tgl;
    logic                  active0, hs0, vs0, vblank;
    logic [AW-1:0]         rd_addr;
    logic                  active1, hs1, vs1;
    logic [COLOR_BITS-1:0] pix1;
    logic [COLOR_BITS-1:0] mem [FB_SIZE];

    logic [7:0]            cur_x, cur_y;
    logic                  wr_cpu, pix_wr, in_range, cpu_we, start;
    logic [AW-1:0]         cur_addr;
    state_t                state, state_next;
    logic                  clr_we, busy;
    logic [AW-1:0]         clr_addr;
    logic [COLOR_BITS-1:0] clr_color;
    logic                  we;
    logic [AW-1:0]         wr_addr;
    logic [COLOR_BITS-1:0] wr_data;

    assign pix_en = (div == DW'(CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sx        <= '0;
            sy        <= '0;
            frame_tgl <= 1'b0;
        end else if (pix_en) begin
            if (sx == HW'(H_TOTAL - 1)) begin
                sx <= '0;
                sy <= (sy == VW'(V_TOTAL - 1)) ? '0 : sy + 1'b1;
                if (sy == VW'(V_ACTIVE - 1)) begin
                    frame_tgl <= ~frame_tgl;
                end
            end else begin
                sx <= sx + 1'b1;
            end
        end
    end

    // One extra bit so sync windows that end exactly at the total still compare correctly
    assign active0 = (sx < HW'(H_ACTIVE)) && (sy < VW'(V_ACTIVE));
    assign hs0     = ({1'b0, sx} >= (HW+1)'(HS_START)) && ({1'b0, sx} < (HW+1)'(HS_END));
    assign vs0     = ({1'b0, sy} >= (VW+1)'(VS_START)) && ({1'b0, sy} < (VW+1)'(VS_END));
    assign vblank  = (sy >= VW'(V_ACTIVE));
    assign rd_addr = active0 ? AW'(sy >> SCALE_SHIFT) * AW'(FB_W) + AW'(sx >> SCALE_SHIFT) : '0;

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (pix_en) begin
            pix1 <= mem[rd_addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            active1 <= 1'b0;
            hs1     <= 1'b0;
            vs1     <= 1'b0;
            R       <= '0;
            G       <= '0;
            B       <= '0;
            Hs      <= ~HS_ACT;
            Vs      <= ~VS_ACT;
        end else if (pix_en) begin
            active1 <= active0;
            hs1     <= hs0;
            vs1     <= vs0;
            R       <= active1 ? pix1[CH_BITS-1:0] : '0;
            G       <= active1 ? pix1[2*CH_BITS-1:CH_BITS] : '0;
            B       <= active1 ? pix1[3*CH_BITS-1:2*CH_BITS] : '0;
            Hs      <= hs1 ? HS_ACT : ~HS_ACT;
            Vs      <= vs1 ? VS_ACT : ~VS_ACT;
        end
    end

    assign wr_cpu   = CE && !RW;
    assign busy     = (state == CLEAR);
    assign pix_wr   = wr_cpu && (ADDR == 2'd2) && !busy;
    assign in_range = ({1'b0, cur_x} < 9'(FB_W)) && ({1'b0, cur_y} < 9'(FB_H));
    assign cpu_we   = pix_wr && in_range;
    assign start    = wr_cpu && (ADDR == 2'd3) && DATA[7];
    assign cur_addr = AW'(cur_y) * AW'(FB_W) + AW'(cur_x);

    always_ff @(posedge CLK) begin
        if (RST) begin
            cur_x <= '0;
            cur_y <= '0;
        end else begin
            if (wr_cpu && ADDR == 2'd0) cur_x <= DATA;
            if (wr_cpu && ADDR == 2'd1) cur_y <= DATA;
            if (cpu_we) begin
                if (cur_x == 8'(FB_W - 1)) begin
                    cur_x <= '0;
                    cur_y <= (cur_y == 8'(FB_H - 1)) ? '0 : cur_y + 1'b1;
                end else begin
                    cur_x <= cur_x + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        clr_we     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (clr_addr == AW'(FB_SIZE - 1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            clr_addr  <= '0;
            clr_color <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                clr_addr  <= '0;
                clr_color <= DATA[COLOR_BITS-1:0];
            end else if (clr_we) begin
                clr_addr <= clr_addr + 1'b1;
            end
        end
    end

    // CPU writes are locked out during CLEAR, so the two sources never collide
    assign we      = clr_we || cpu_we;
    assign wr_addr = clr_we ? clr_addr : cur_addr;
    assign wr_data = clr_we ? clr_color : DATA[COLOR_BITS-1:0];

    always_comb begin
        DATA_OUT = '0;
        if (CE && RW) begin
            case (ADDR)
                2'd0:    DATA_OUT = cur_x;
                2'd1:    DATA_OUT = cur_y;
                2'd3:    DATA_OUT = {5'b0, busy, vblank, frame_tgl};
                default: DATA_OUT = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_controller.sv
// Bench for vga_fb_controller on a reduced raster: pixel stream, syncs and status are
// predicted arithmetically from elapsed clocks; the framebuffer is modelled as an array.
module tb_vga_fb_controller;
    localparam int HA = 32, HF = 4, HSY = 8, HB = 4;
    localparam int VA = 16, VF = 2, VSY = 2, VB = 4;
    localparam int D = 2, SS = 2, CH = 1, VSP = 1;
    localparam int HT = HA + HF + HSY + HB;
    localparam int VT = VA + VF + VSY + VB;
    localparam int F = HT * VT;
    localparam int FBW = HA >> SS, FBH = VA >> SS, FBN = FBW * FBH, CB = 3 * CH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0, rw = 1'b1;
    logic [1:0]    addr = '0;
    logic [7:0]    data = '0;
    logic [7:0]    dout;
    logic [CH-1:0] r, g, b;
    logic          hs, vs;

    vga_fb_controller #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .HS_POL(0), .VS_POL(VSP), .CLK_DIV(D), .SCALE_SHIFT(SS), .CH_BITS(CH)
    ) dut (
        .CLK(clk), .RST(rst), .CE(ce), .RW(rw), .ADDR(addr), .DATA(data),
        .DATA_OUT(dout), .R(r), .G(g), .B(b), .Hs(hs), .Vs(vs)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    int nvec = 0, nerr = 0;
    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    logic [CB-1:0] mem_m [FBN];
    bit            known [FBN];
    int            cx = 0, cy = 0, samp = 0;
    bit            m_busy = 0, vid_on = 0, col_chk = 0;

    // Expected video: after n pixel ticks the outputs show raster position n-2
    always @(negedge clk) begin : vid_chk
        int n, p, sx, sy, idx, col, er, eg, eb, ehs, evs;
        bit cmpcol;
        if (vid_on) begin
            n = edges / D;
            ehs = 1; evs = 1 - VSP; er = 0; eg = 0; eb = 0; cmpcol = 1;
            if (n >= 2) begin
                p  = (n - 2) % F;
                sx = p % HT;
                sy = p / HT;
                if (sx >= HA + HF && sx < HA + HF + HSY) ehs = 0;
                if (sy >= VA + VF && sy < VA + VF + VSY) evs = VSP;
                if (sx < HA && sy < VA) begin
                    idx = (sy >> SS) * FBW + (sx >> SS);
                    if (known[idx] && col_chk) begin
                        col = int'(mem_m[idx]);
                        er = col & 1; eg = (col >> 1) & 1; eb = (col >> 2) & 1;
                    end else begin
                        cmpcol = 0;
                    end
                end
            end
            chk("hs", int'(hs), ehs);
            chk("vs", int'(vs), evs);
            if (cmpcol) begin
                chk("r", int'(r), er);
                chk("g", int'(g), eg);
                chk("b", int'(b), eb);
            end
        end
    end

    function automatic int exp_status(input int e, input bit bsy);
        int n, cnt;
        n   = e / D;
        cnt = (n >= VA * HT) ? (n - VA * HT) / F + 1 : 0;
        return (int'(bsy) << 2) | ((((n % F) / HT) >= VA) ? 2 : 0) | (cnt & 1);
    endfunction

    task automatic model_write(input int a, input int d);
        case (a)
            0: cx = d & 255;
            1: cy = d & 255;
            2: if (!m_busy && cx < FBW && cy < FBH) begin
                mem_m[cy * FBW + cx] = CB'(d);
                known[cy * FBW + cx] = 1;
                if (cx == FBW - 1) begin
                    cx = 0;
                    cy = (cy == FBH - 1) ? 0 : cy + 1;
                end else begin
                    cx++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic bus(input bit c, input bit rwi, input int a, input int d, output int q);
        @(negedge clk);
        ce = c; rw = rwi; addr = 2'(a); data = 8'(d);
        #1;
        q = int'(dout);
        samp = edges;
        @(negedge clk);
        ce = 1'b0; rw = 1'b1; addr = '0; data = '0;
        if (c && !rwi) model_write(a, d);
    endtask

    // Polls STATUS every clock; returns how many consecutive samples showed busy
    task automatic wait_idle(output int cnt);
        cnt = 0;
        ce = 1'b1; rw = 1'b1; addr = 2'd3;
        for (int i = 0; i < 8 * FBN; i++) begin
            #1;
            if (!dout[2]) break;
            cnt++;
            @(negedge clk);
        end
        ce = 1'b0;
    endtask

    task automatic fill_model(input int col);
        for (int i = 0; i < FBN; i++) begin
            mem_m[i] = CB'(col);
            known[i] = 1;
        end
    endtask

    task automatic show_frame();
        repeat (8) @(negedge clk);
        col_chk = 1;
        repeat (F * D + 100) @(negedge clk);
        col_chk = 0;
    endtask

    typedef struct {
        bit    ce;
        bit    rw;
        int    a;
        int    d;
        int    mask;
        int    exp;
        string nm;
    } vec_t;

    vec_t tbl[$];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int q, cnt;
        for (int i = 0; i < FBN; i++) known[i] = 0;

        tbl.push_back('{1, 0, 0,    3, 'hFF,   0, "wr_x_dout"});
        tbl.push_back('{1, 0, 1,    2, 'hFF,   0, "wr_y_dout"});
        tbl.push_back('{1, 1, 0,    0, 'hFF,   3, "rd_x"});
        tbl.push_back('{1, 1, 1,    0, 'hFF,   2, "rd_y"});
        tbl.push_back('{1, 0, 2,    5, 'hFF,   0, "pix_3_2"});
        tbl.push_back('{1, 1, 0,    0, 'hFF,   4, "rd_x_inc"});
        tbl.push_back('{1, 1, 1,    0, 'hFF,   2, "rd_y_inc"});
        tbl.push_back('{1, 1, 2,    0, 'hFF,   0, "rd_pixel"});
        tbl.push_back('{1, 0, 0,    7, 'hFF,   0, "wr_x7"});
        tbl.push_back('{1, 0, 1,    1, 'hFF,   0, "wr_y1"});
        tbl.push_back('{1, 0, 2,    3, 'hFF,   0, "pix_7_1"});
        tbl.push_back('{1, 0, 2,    6, 'hFF,   0, "pix_0_2"});
        tbl.push_back('{1, 1, 0,    0, 'hFF,   1, "rd_x_wrap"});
        tbl.push_back('{1, 1, 1,    0, 'hFF,   2, "rd_y_wrap"});
        tbl.push_back('{1, 0, 0,    7, 'hFF,   0, "wr_x7b"});
        tbl.push_back('{1, 0, 1,    3, 'hFF,   0, "wr_y3"});
        tbl.push_back('{1, 0, 2,    2, 'hFF,   0, "pix_last"});
        tbl.push_back('{1, 1, 0,    0, 'hFF,   0, "rd_x_corner"});
        tbl.push_back('{1, 1, 1,    0, 'hFF,   0, "rd_y_corner"});
        tbl.push_back('{1, 0, 0,  200, 'hFF,   0, "wr_x200"});
        tbl.push_back('{1, 0, 2,    7, 'hFF,   0, "pix_drop_x"});
        tbl.push_back('{1, 1, 0,    0, 'hFF, 200, "rd_x_drop"});
        tbl.push_back('{1, 1, 1,    0, 'hFF,   0, "rd_y_drop"});
        tbl.push_back('{1, 0, 0,    2, 'hFF,   0, "wr_x2"});
        tbl.push_back('{1, 0, 1,    9, 'hFF,   0, "wr_y9"});
        tbl.push_back('{1, 0, 2,    1, 'hFF,   0, "pix_drop_y"});
        tbl.push_back('{1, 1, 0,    0, 'hFF,   2, "rd_x_dropy"});
        tbl.push_back('{1, 1, 1,    0, 'hFF,   9, "rd_y_dropy"});
        tbl.push_back('{0, 1, 0,    0, 'hFF,   0, "rd_no_ce"});
        tbl.push_back('{1, 0, 3,    5, 'hFF,   0, "ctrl_nostart"});
        tbl.push_back('{1, 1, 3,    0, 'hFC,   0, "status_idle"});
        tbl.push_back('{1, 0, 1,    0, 'hFF,   0, "wr_y0"});

        // Reset state
        repeat (4) @(negedge clk);
        vid_on = 1;
        rst = 0;
        bus(1, 1, 3, 0, q);
        chk("status_reset", q, exp_status(samp, 0));
        bus(1, 1, 0, 0, q);
        chk("x_reset", q, 0);

        // Full clear: busy length and resulting image
        bus(1, 0, 3, 'h86, q);
        wait_idle(cnt);
        chk("busy_len", cnt, FBN);
        fill_model('h86 & 7);
        show_frame();

        foreach (tbl[i]) begin
            bus(tbl[i].ce, tbl[i].rw, tbl[i].a, tbl[i].d, q);
            chk(tbl[i].nm, q & tbl[i].mask, tbl[i].exp);
        end
        show_frame();

        // Random cursor/pixel traffic against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       bus(1, 0, 0, int'($urandom_range(0, FBW + 1)), q);
                1:       bus(1, 0, 1, int'($urandom_range(0, FBH + 1)), q);
                default: bus(1, 0, 2, int'($urandom_range(0, 255)), q);
            endcase
        end
        bus(1, 1, 0, 0, q);
        chk("rand_x", q, cx);
        bus(1, 1, 1, 0, q);
        chk("rand_y", q, cy);
        show_frame();

        // Status sampled at random points across about two frames
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 200)) @(negedge clk);
            bus(1, 1, 3, 0, q);
            chk("status_rand", q, exp_status(samp, 0));
        end

        // Clear interlock: pixel and CTRL writes ignored, X still accepted
        bus(1, 0, 0, 1, q);
        bus(1, 0, 1, 1, q);
        bus(1, 0, 3, 'h83, q);
        m_busy = 1;
        bus(1, 1, 3, 0, q);
        chk("status_busy", q & 4, 4);
        bus(1, 0, 2, 4, q);
        bus(1, 0, 3, 'h85, q);
        bus(1, 0, 0, 5, q);
        wait_idle(cnt);
        chk("busy_drains", int'(cnt < 8 * FBN), 1);
        m_busy = 0;
        fill_model(3);
        bus(1, 1, 0, 0, q);
        chk("x_in_clear", q, 5);
        bus(1, 1, 1, 0, q);
        chk("y_in_clear", q, 1);
        show_frame();

        // Reset in the middle of a clear
        bus(1, 0, 0, 3, q);
        bus(1, 0, 3, 'h87, q);
        repeat (16) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        cx = 0; cy = 0;
        for (int i = 0; i < FBN; i++) known[i] = 0;
        bus(1, 1, 3, 0, q);
        chk("status_after_rst", q, exp_status(samp, 0));
        bus(1, 1, 0, 0, q);
        chk("x_after_rst", q, 0);
        repeat (F * D + 50) @(negedge clk);

        vid_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
